// File: rtl/reg_exec_ctrl_pkg.sv
// reg_exec_ctrl_pkg: opcodes, FSM states and defaults shared by the register-transfer sequencer.
package reg_exec_ctrl_pkg;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 2;
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_MOV  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_INC  = 3'd5,
    OP_LDI  = 3'd6,
    OP_SWAP = 3'd7
  } op_e;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_WB2  = 3'd4
  } state_e;
  function automatic logic op_sets_flags(op_e op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_INC};
  endfunction
endpackage

// File: rtl/reg_exec_alu.sv
// reg_exec_alu: combinational result and z/c flags; a is the source operand, b the destination operand.
module reg_exec_alu
  import reg_exec_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  op_e           op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] result,
  output logic          z,
  output logic          c
);
  logic [DW:0] sum, dif, inc;
  assign sum = {1'b0, b} + {1'b0, a};
  assign dif = {1'b0, b} - {1'b0, a};
  assign inc = {1'b0, b} + {{DW{1'b0}}, 1'b1};
  always_comb begin
    result = '0;
    c = 1'b0;
    case (op)
      OP_MOV:  result = a;
      OP_ADD:  {c, result} = sum;
      OP_SUB:  {c, result} = dif;
      OP_AND:  result = b & a;
      OP_INC:  {c, result} = inc;
      OP_LDI:  result = imm;
      OP_SWAP: result = b;
      default: result = '0;
    endcase
    z = (result == '0);
  end
endmodule

// File: rtl/reg_exec_ctrl.sv
// reg_exec_ctrl: one-instruction-at-a-time sequencer driving the 4x8 register group write port.
// All outputs are registered except instr_ready, which is simply "FSM idle".
module reg_exec_ctrl
  import reg_exec_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_sr,
  input  logic [AW-1:0] instr_dr,
  input  logic [DW-1:0] instr_imm,
  output logic          rf_we,
  output logic [AW-1:0] rf_sr,
  output logic [AW-1:0] rf_dr,
  output logic [DW-1:0] rf_i,
  input  logic [DW-1:0] rf_s,
  input  logic [DW-1:0] rf_d,
  output logic          done,
  output logic          flag_z,
  output logic          flag_c
);
  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [AW-1:0] sr_q, sr_d, dr_q, dr_d, rf_sr_q, rf_sr_d, rf_dr_q, rf_dr_d;
  logic [DW-1:0] imm_q, imm_d, a_q, a_d, b_q, b_d, rf_i_q, rf_i_d;
  logic          rf_we_q, rf_we_d, done_q, done_d, z_q, z_d, c_q, c_d;
  logic [DW-1:0] alu_res;
  logic          alu_z, alu_c;
  reg_exec_alu #(.DW(DW)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c)
  );
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sr_d    = sr_q;
    dr_d    = dr_q;
    imm_d   = imm_q;
    a_d     = a_q;
    b_d     = b_q;
    rf_sr_d = rf_sr_q;
    rf_dr_d = rf_dr_q;
    rf_i_d  = rf_i_q;
    rf_we_d = 1'b0;
    done_d  = 1'b0;
    z_d     = z_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: if (instr_valid) begin
        state_d = S_READ;
        op_d    = op_e'(instr_op);
        sr_d    = instr_sr;
        dr_d    = instr_dr;
        imm_d   = instr_imm;
        rf_sr_d = instr_sr;
        rf_dr_d = instr_dr;
      end
      S_READ: begin
        state_d = S_EXEC;
        a_d     = rf_s;
        b_d     = rf_d;
      end
      // SWAP writes the old R[dr] into R[sr] first, then the old R[sr] into R[dr] in WB2
      S_EXEC: begin
        state_d = S_WB;
        rf_we_d = (op_q != OP_NOP);
        rf_dr_d = (op_q == OP_SWAP) ? sr_q : dr_q;
        rf_i_d  = (op_q == OP_SWAP) ? b_q : alu_res;
        done_d  = (op_q != OP_SWAP);
        z_d     = op_sets_flags(op_q) ? alu_z : z_q;
        c_d     = op_sets_flags(op_q) ? alu_c : c_q;
      end
      S_WB: if (op_q == OP_SWAP) begin
        state_d = S_WB2;
        rf_we_d = 1'b1;
        rf_dr_d = dr_q;
        rf_i_d  = a_q;
        done_d  = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      sr_q    <= '0;
      dr_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rf_sr_q <= '0;
      rf_dr_q <= '0;
      rf_i_q  <= '0;
      rf_we_q <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sr_q    <= sr_d;
      dr_q    <= dr_d;
      imm_q   <= imm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rf_sr_q <= rf_sr_d;
      rf_dr_q <= rf_dr_d;
      rf_i_q  <= rf_i_d;
      rf_we_q <= rf_we_d;
      done_q  <= done_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end
  assign instr_ready = (state_q == S_IDLE);
  assign rf_we       = rf_we_q;
  assign rf_sr       = rf_sr_q;
  assign rf_dr       = rf_dr_q;
  assign rf_i        = rf_i_q;
  assign done        = done_q;
  assign flag_z      = z_q;
  assign flag_c      = c_q;
endmodule

// File: tb/tb_reg_exec_ctrl.sv
// tb_reg_exec_ctrl: drives reg_exec_ctrl against a negedge-writing register group model.
module tb_reg_exec_ctrl;
  import reg_exec_ctrl_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = 3'd0;
  logic [1:0] instr_sr = 2'd0, instr_dr = 2'd0;
  logic [7:0] instr_imm = 8'd0;
  logic       rf_we, done, flag_z, flag_c;
  logic [1:0] rf_sr, rf_dr;
  logic [7:0] rf_i, rf_s, rf_d;
  logic [7:0] rg [4];
  int         we_cnt = 0;
  int         checks = 0, errors = 0;
  typedef struct {
    logic [2:0] op;
    logic [1:0] sr, dr;
    logic [7:0] imm, res;
    logic       z, c;
    int         we;
  } vec_t;
  vec_t vt [16];
  vec_t sb [$];
  always #5 clk = ~clk;
  reg_exec_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_sr    (instr_sr),
    .instr_dr    (instr_dr),
    .instr_imm   (instr_imm),
    .rf_we       (rf_we),
    .rf_sr       (rf_sr),
    .rf_dr       (rf_dr),
    .rf_i        (rf_i),
    .rf_s        (rf_s),
    .rf_d        (rf_d),
    .done        (done),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
  );
  assign rf_s = rg[rf_sr];
  assign rf_d = rg[rf_dr];
  always @(negedge clk) if (rf_we) begin
    rg[rf_dr] <= rf_i;
    we_cnt <= we_cnt + 1;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [2:0] op, input logic [1:0] sr, input logic [1:0] dr, input logic [7:0] imm);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op = op;
    instr_sr = sr;
    instr_dr = dr;
    instr_imm = imm;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask
  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1 edges++;
    end while (!done && edges < 12);
    if (!done) chk("done_timeout", 0, 1);
  endtask
  task automatic run_vec(input vec_t v);
    int   edges, w0;
    vec_t e;
    w0 = we_cnt;
    sb.push_back(v);
    drive(v.op, v.sr, v.dr, v.imm);
    wait_done(edges);
    if (done) begin
      e = sb.pop_front();
      chk("latency", edges, 2);
      chk("flag_z", flag_z, e.z);
      chk("flag_c", flag_c, e.c);
      @(negedge clk);
      #1;
      chk("reg_value", rg[e.dr], e.res);
      chk("write_count", we_cnt - w0, e.we);
    end
  endtask
  initial begin
    int   edges, acc, cyc, last;
    logic hs;
    vt[0]  = '{OP_LDI, 2'd0, 2'd1, 8'h3C, 8'h3C, 1'b0, 1'b0, 1};
    vt[1]  = '{OP_LDI, 2'd0, 2'd1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1};
    vt[2]  = '{OP_LDI, 2'd0, 2'd2, 8'h01, 8'h01, 1'b0, 1'b0, 1};
    vt[3]  = '{OP_ADD, 2'd2, 2'd1, 8'h00, 8'h00, 1'b1, 1'b1, 1};
    vt[4]  = '{OP_INC, 2'd0, 2'd1, 8'h00, 8'h01, 1'b0, 1'b0, 1};
    vt[5]  = '{OP_LDI, 2'd0, 2'd0, 8'h05, 8'h05, 1'b0, 1'b0, 1};
    vt[6]  = '{OP_LDI, 2'd0, 2'd3, 8'h07, 8'h07, 1'b0, 1'b0, 1};
    vt[7]  = '{OP_SUB, 2'd3, 2'd0, 8'h00, 8'hFE, 1'b0, 1'b1, 1};
    vt[8]  = '{OP_SUB, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1};
    vt[9]  = '{OP_MOV, 2'd3, 2'd2, 8'h00, 8'h07, 1'b1, 1'b0, 1};
    vt[10] = '{OP_AND, 2'd3, 2'd1, 8'h00, 8'h01, 1'b0, 1'b0, 1};
    vt[11] = '{OP_ADD, 2'd1, 2'd1, 8'h00, 8'h02, 1'b0, 1'b0, 1};
    vt[12] = '{OP_LDI, 2'd0, 2'd3, 8'hF0, 8'hF0, 1'b0, 1'b0, 1};
    vt[13] = '{OP_NOP, 2'd0, 2'd3, 8'h11, 8'hF0, 1'b0, 1'b0, 0};
    vt[14] = '{OP_LDI, 2'd0, 2'd1, 8'hAA, 8'hAA, 1'b0, 1'b0, 1};
    vt[15] = '{OP_LDI, 2'd0, 2'd2, 8'h55, 8'h55, 1'b0, 1'b0, 1};
    #12;
    chk("rst_ready", instr_ready, 1);
    chk("rst_we", rf_we, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {flag_z, flag_c}, 0);
    chk("rst_rf", {rf_sr, rf_dr, rf_i}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) run_vec(vt[i]);
    drive(OP_SWAP, 2'd1, 2'd2, 8'h00);
    @(posedge clk);
    #1 chk("swap_exec_we", rf_we, 0);
    @(posedge clk);
    #1;
    chk("swap_wb_we", rf_we, 1);
    chk("swap_wb_dr", rf_dr, 1);
    chk("swap_wb_i", rf_i, 8'h55);
    chk("swap_wb_done", done, 0);
    @(negedge clk);
    #1 chk("swap_r1", rg[1], 8'h55);
    @(posedge clk);
    #1;
    chk("swap_wb2_done", done, 1);
    chk("swap_wb2_dr", rf_dr, 2);
    chk("swap_wb2_i", rf_i, 8'hAA);
    @(negedge clk);
    #1 chk("swap_r2", rg[2], 8'hAA);
    @(posedge clk);
    #1;
    chk("swap_end_ready", instr_ready, 1);
    chk("swap_end_done", {done, rf_we}, 0);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op = OP_INC;
    instr_sr = 2'd0;
    instr_dr = 2'd0;
    acc = 0;
    cyc = 0;
    last = 0;
    while (acc < 3 && cyc < 40) begin
      hs = instr_ready;
      @(posedge clk);
      #1 cyc++;
      if (hs) begin
        acc++;
        if (acc > 1) chk("hold_spacing", cyc - last, 4);
        last = cyc;
        chk("hold_busy", instr_ready, 0);
        if (acc == 3) instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("hold_accepts", acc, 3);
    wait_done(edges);
    @(negedge clk);
    #1;
    chk("hold_r0", rg[0], 8'h03);
    chk("hold_flags", {flag_z, flag_c}, 2'b00);
    drive(OP_SWAP, 2'd1, 2'd2, 8'h00);
    wait_done(edges);
    chk("rst_swap_latency", edges, 3);
    chk("rst_wb2_we", rf_we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_we", rf_we, 0);
    chk("rst_async_ready", instr_ready, 1);
    chk("rst_async_done", done, 0);
    @(negedge clk);
    #1;
    chk("rst_r2_kept", rg[2], 8'hAA);
    chk("rst_r1_written", rg[1], 8'hAA);
    rst_n = 1'b1;
    run_vec('{OP_LDI, 2'd0, 2'd3, 8'h5A, 8'h5A, 1'b0, 1'b0, 1});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
